axis_pulse_seq_meas: RTL and testbench



---
 rtl/axis_pulse_seq_pkg.sv | 36 +++
 rtl/axis_pulse_seq_player.sv | 74 +++++++
 rtl/axis_pulse_seq_meas.sv | 155 +++++++++++++++
 tb/tb_axis_pulse_seq_meas.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pulse_seq_pkg.sv
// Shared types and cfg_data field layout for the pulse sequencer / measurement block.
package axis_pulse_seq_pkg;

    typedef enum logic [2:0] {
        ST_SKIP     = 3'd0,
        ST_PRE_OFF  = 3'd1,
        ST_RAMP_UP  = 3'd2,
        ST_PULSE    = 3'd3,
        ST_RAMP_DN  = 3'd4,
        ST_POST_OFF = 3'd5,
        ST_EVAL     = 3'd6
    } meas_state_e;

    // Length fields are indexed in units of CNTR_WIDTH from bit 0; the two 32-bit
    // words follow the length fields and are offset relative to their end.
    localparam int unsigned CFG_IDX_OFFSET_START = 0;
    localparam int unsigned CFG_IDX_OFFSET_WIDTH = 1;
    localparam int unsigned CFG_IDX_RAMP         = 2;
    localparam int unsigned CFG_IDX_WIDTH        = 3;
    localparam int unsigned CFG_NUM_LEN_FIELDS   = 4;
    localparam int unsigned CFG_THRESHOLD_REL    = 0;
    localparam int unsigned CFG_SEG_LEN_REL      = 32;

    function automatic meas_state_e next_state(input meas_state_e st);
        case (st)
            ST_SKIP:     return ST_PRE_OFF;
            ST_PRE_OFF:  return ST_RAMP_UP;
            ST_RAMP_UP:  return ST_PULSE;
            ST_PULSE:    return ST_RAMP_DN;
            ST_RAMP_DN:  return ST_POST_OFF;
            ST_POST_OFF: return ST_EVAL;
            default:     return ST_SKIP;
        endcase
    endfunction

endpackage

// File: rtl/axis_pulse_seq_player.sv
// Waveform playback: walks the points of the current BRAM segment and switches
// segment only when the last point of a segment is accepted.
module axis_pulse_seq_player
    import axis_pulse_seq_pkg::*;
#(
    parameter int SEG_W           = 2,
    parameter int BRAM_ADDR_WIDTH = 10
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [31:0]                seg_len_i,
    input  logic [SEG_W-1:0]           pending_seg_i,
    input  logic                       m_tready_i,
    output logic                       m_tvalid_o,
    output logic                       m_tlast_o,
    output logic [BRAM_ADDR_WIDTH-1:0] bram_addr_o,
    output logic [SEG_W-1:0]           seg_index_o
);

    logic [31:0]                point_q;
    logic [SEG_W-1:0]           seg_q;
    logic                       tvalid_q;
    logic [31:0]                len_eff_s;
    logic [31:0]                last_pt_s;
    logic                       at_end_s;
    logic                       fire_s;
    logic [31:0]                point_nx_s;
    logic [SEG_W-1:0]           seg_nx_s;
    logic [BRAM_ADDR_WIDTH-1:0] cur_addr_s;
    logic [BRAM_ADDR_WIDTH-1:0] nxt_addr_s;

    function automatic logic [BRAM_ADDR_WIDTH-1:0] seg_addr(
        input logic [SEG_W-1:0] seg,
        input logic [31:0]      len,
        input logic [31:0]      pt
    );
        return BRAM_ADDR_WIDTH'(seg) * BRAM_ADDR_WIDTH'(len) + BRAM_ADDR_WIDTH'(pt);
    endfunction

    // Next point/segment decode; a zero segment length behaves as a one-point segment.
    always_comb begin
        len_eff_s  = (seg_len_i == 32'd0) ? 32'd1 : seg_len_i;
        last_pt_s  = len_eff_s - 32'd1;
        at_end_s   = (point_q >= last_pt_s);
        fire_s     = tvalid_q & m_tready_i;
        point_nx_s = at_end_s ? 32'd0 : (point_q + 32'd1);
        seg_nx_s   = at_end_s ? pending_seg_i : seg_q;
        cur_addr_s = seg_addr(seg_q, len_eff_s, point_q);
        nxt_addr_s = seg_addr(seg_nx_s, len_eff_s, point_nx_s);
    end

    // Point / segment registers, advanced only on accepted beats.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            point_q  <= 32'd0;
            seg_q    <= {SEG_W{1'b0}};
            tvalid_q <= 1'b0;
        end else begin
            tvalid_q <= 1'b1;
            if (fire_s) begin
                point_q <= point_nx_s;
                seg_q   <= seg_nx_s;
            end
        end
    end

    // The BRAM registers its address, so presenting the upcoming address on an
    // accepted beat keeps read data aligned with point_q.
    assign bram_addr_o = fire_s ? nxt_addr_s : cur_addr_s;
    assign m_tvalid_o  = tvalid_q;
    assign m_tlast_o   = (point_q == last_pt_s);
    assign seg_index_o = seg_q;

endmodule

// File: rtl/axis_pulse_seq_meas.sv
// Pulse measurement: integrates offset and pulse windows of the input stream each
// period and chooses the next playback segment from the result vs. threshold.
module axis_pulse_seq_meas
    import axis_pulse_seq_pkg::*;
#(
    parameter int AXIS_TDATA_WIDTH = 16,
    parameter int CNTR_WIDTH       = 16,
    parameter int ACC_WIDTH        = 40,
    parameter int NUM_SEG          = 4,
    parameter int BRAM_ADDR_WIDTH  = 10,
    parameter int BRAM_DATA_WIDTH  = 16
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [CNTR_WIDTH*4+63:0]    cfg_data,
    output logic [31:0]                 sts_data,
    output logic                        overload,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    output logic [BRAM_DATA_WIDTH-1:0]  m_axis_tdata,
    output logic                        m_axis_tvalid,
    output logic                        m_axis_tlast,
    input  logic                        m_axis_tready,
    output logic                        bram_porta_clk,
    output logic                        bram_porta_rst,
    output logic [BRAM_ADDR_WIDTH-1:0]  bram_porta_addr,
    input  logic [BRAM_DATA_WIDTH-1:0]  bram_porta_rddata
);

    localparam int SEG_W    = (NUM_SEG > 2) ? $clog2(NUM_SEG) : 1;
    localparam int LEN_BASE = CFG_NUM_LEN_FIELDS * CNTR_WIDTH;

    logic [CNTR_WIDTH-1:0]       offset_start_s, offset_width_s, ramp_s, width_s;
    logic [31:0]                 threshold_s, seg_len_s;
    meas_state_e                 state_q, eff_state_s;
    logic [CNTR_WIDTH-1:0]       cntr_q, cntr_eff_s, eff_len_s;
    logic                        last_beat_s, eval_s, eval_done_q;
    logic signed [ACC_WIDTH-1:0] offset_acc_q, pulse_acc_q, result_q;
    logic signed [ACC_WIDTH-1:0] sample_ext_s, thr_ext_s, result_d_s;
    logic [SEG_W-1:0]            pending_q, pending_d, seg_index_s;
    logic [23:0]                 period_q;
    logic                        overload_q;

    assign offset_start_s = cfg_data[CFG_IDX_OFFSET_START*CNTR_WIDTH +: CNTR_WIDTH];
    assign offset_width_s = cfg_data[CFG_IDX_OFFSET_WIDTH*CNTR_WIDTH +: CNTR_WIDTH];
    assign ramp_s         = cfg_data[CFG_IDX_RAMP*CNTR_WIDTH +: CNTR_WIDTH];
    assign width_s        = cfg_data[CFG_IDX_WIDTH*CNTR_WIDTH +: CNTR_WIDTH];
    assign threshold_s    = cfg_data[LEN_BASE+CFG_THRESHOLD_REL +: 32];
    assign seg_len_s      = cfg_data[LEN_BASE+CFG_SEG_LEN_REL +: 32];

    function automatic logic [CNTR_WIDTH-1:0] state_len(
        input meas_state_e           st,
        input logic [CNTR_WIDTH-1:0] os,
        input logic [CNTR_WIDTH-1:0] ow,
        input logic [CNTR_WIDTH-1:0] rp,
        input logic [CNTR_WIDTH-1:0] wd
    );
        case (st)
            ST_SKIP:                return os;
            ST_PRE_OFF, ST_POST_OFF: return ow;
            ST_RAMP_UP, ST_RAMP_DN: return rp;
            ST_PULSE:               return wd;
            default:                return {CNTR_WIDTH{1'b0}};
        endcase
    endfunction

    // Zero-length windows are skipped in the same cycle, so the beat on the
    // wire is credited to the first window that actually has a length.
    always_comb begin
        eff_state_s = state_q;
        for (int i = 0; i < 6; i++) begin
            eff_state_s = (eff_state_s != ST_EVAL &&
                           state_len(eff_state_s, offset_start_s, offset_width_s, ramp_s, width_s)
                               == {CNTR_WIDTH{1'b0}}) ? next_state(eff_state_s) : eff_state_s;
        end
        eff_len_s    = state_len(eff_state_s, offset_start_s, offset_width_s, ramp_s, width_s);
        cntr_eff_s   = (eff_state_s == state_q) ? cntr_q : {CNTR_WIDTH{1'b0}};
        last_beat_s  = ({1'b0, cntr_eff_s} + (CNTR_WIDTH+1)'(1)) >= {1'b0, eff_len_s};
        eval_s       = (eff_state_s == ST_EVAL);
        sample_ext_s = {{(ACC_WIDTH-AXIS_TDATA_WIDTH){s_axis_tdata[AXIS_TDATA_WIDTH-1]}}, s_axis_tdata};
        thr_ext_s    = {{(ACC_WIDTH-32){threshold_s[31]}}, threshold_s};
        result_d_s   = pulse_acc_q - offset_acc_q;
        if (eval_s) begin
            pending_d = (result_d_s < thr_ext_s) ? (seg_index_s + SEG_W'(1)) : {SEG_W{1'b0}};
        end else begin
            pending_d = pending_q;
        end
    end

    // Measurement FSM with accumulators, period counter and overload flag.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= ST_SKIP;
            cntr_q       <= {CNTR_WIDTH{1'b0}};
            offset_acc_q <= {ACC_WIDTH{1'b0}};
            pulse_acc_q  <= {ACC_WIDTH{1'b0}};
            result_q     <= {ACC_WIDTH{1'b0}};
            pending_q    <= {SEG_W{1'b0}};
            period_q     <= 24'd0;
            eval_done_q  <= 1'b0;
            overload_q   <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            eval_done_q <= eval_s;
            if (eval_done_q) begin
                overload_q <= (result_q < thr_ext_s);
            end
            if (eval_s) begin
                result_q     <= result_d_s;
                offset_acc_q <= {ACC_WIDTH{1'b0}};
                pulse_acc_q  <= {ACC_WIDTH{1'b0}};
                period_q     <= period_q + 24'd1;
                state_q      <= ST_SKIP;
                cntr_q       <= {CNTR_WIDTH{1'b0}};
            end else if (s_axis_tvalid) begin
                case (eff_state_s)
                    ST_PRE_OFF, ST_POST_OFF: offset_acc_q <= offset_acc_q + sample_ext_s;
                    ST_PULSE:                pulse_acc_q  <= pulse_acc_q + sample_ext_s;
                    default:                 ;
                endcase
                if (last_beat_s) begin
                    state_q <= next_state(eff_state_s);
                    cntr_q  <= {CNTR_WIDTH{1'b0}};
                end else begin
                    state_q <= eff_state_s;
                    cntr_q  <= cntr_eff_s + CNTR_WIDTH'(1);
                end
            end
        end
    end

    axis_pulse_seq_player #(
        .SEG_W           (SEG_W),
        .BRAM_ADDR_WIDTH (BRAM_ADDR_WIDTH)
    ) u_player (
        .clk_i         (aclk),
        .rst_ni        (aresetn),
        .seg_len_i     (seg_len_s),
        .pending_seg_i (pending_d),
        .m_tready_i    (m_axis_tready),
        .m_tvalid_o    (m_axis_tvalid),
        .m_tlast_o     (m_axis_tlast),
        .bram_addr_o   (bram_porta_addr),
        .seg_index_o   (seg_index_s)
    );

    assign sts_data       = {8'(seg_index_s), period_q};
    assign overload       = overload_q;
    assign s_axis_tready  = 1'b1;
    assign m_axis_tdata   = bram_porta_rddata;
    assign bram_porta_clk = aclk;
    assign bram_porta_rst = ~aresetn;

endmodule

// File: tb/tb_axis_pulse_seq_meas.sv
// Directed bench for axis_pulse_seq_meas with a registered-read BRAM model.
module tb_axis_pulse_seq_meas;

    logic         aclk;
    logic         aresetn;
    logic [127:0] cfg_data;
    logic [31:0]  sts_data;
    logic         overload;
    logic [15:0]  s_tdata;
    logic         s_tvalid, s_tready;
    logic [15:0]  m_tdata;
    logic         m_tvalid, m_tlast, m_tready;
    logic         bram_clk, bram_rst;
    logic [9:0]   bram_addr;
    logic [15:0]  bram_rddata;

    logic [15:0]  os_v, ow_v, rp_v, wd_v;
    logic [31:0]  thr_v, seglen_v;
    int           n_checks = 0;
    int           n_fail   = 0;

    assign cfg_data = {seglen_v, thr_v, wd_v, rp_v, ow_v, os_v};

    axis_pulse_seq_meas dut (
        .aclk              (aclk),
        .aresetn           (aresetn),
        .cfg_data          (cfg_data),
        .sts_data          (sts_data),
        .overload          (overload),
        .s_axis_tdata      (s_tdata),
        .s_axis_tvalid     (s_tvalid),
        .s_axis_tready     (s_tready),
        .m_axis_tdata      (m_tdata),
        .m_axis_tvalid     (m_tvalid),
        .m_axis_tlast      (m_tlast),
        .m_axis_tready     (m_tready),
        .bram_porta_clk    (bram_clk),
        .bram_porta_rst    (bram_rst),
        .bram_porta_addr   (bram_addr),
        .bram_porta_rddata (bram_rddata)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    function automatic logic [15:0] mem_f(input logic [9:0] a);
        logic [15:0] t;
        t = {6'd0, a} * 16'd7 + 16'h1234;
        return t;
    endfunction

    always @(posedge aclk) bram_rddata <= mem_f(bram_addr);

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        aresetn  = 1'b0;
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
    endtask

    task automatic set_std_cfg(input logic [31:0] thr);
        os_v = 16'd2; ow_v = 16'd4; rp_v = 16'd1; wd_v = 16'd8;
        seglen_v = 32'd8; thr_v = thr;
    endtask

    // One full period: offset windows carry off_v, pulse carries pulse_v, rest 0.
    // Returns two cycles after EVAL so the overload flag is settled.
    task automatic run_period(input logic [15:0] off_v, input logic [15:0] pulse_v);
        int b0, b1, b2, b3, b4, b5;
        b0 = int'(os_v); b1 = b0 + int'(ow_v); b2 = b1 + int'(rp_v);
        b3 = b2 + int'(wd_v); b4 = b3 + int'(rp_v); b5 = b4 + int'(ow_v);
        for (int i = 0; i < b5; i++) begin
            s_tvalid = 1'b1;
            if ((i >= b0 && i < b1) || i >= b4) s_tdata = off_v;
            else if (i >= b2 && i < b3)        s_tdata = pulse_v;
            else                               s_tdata = 16'd0;
            @(negedge aclk);
        end
        s_tvalid = 1'b0;
        s_tdata  = 16'd0;
        repeat (2) @(negedge aclk);
    endtask

    task automatic play_segment(input int exp_seg, input bit toggle);
        int p;
        int cyc;
        bit rdy;
        logic [9:0] a;
        p = 0;
        cyc = 0;
        while (p < 8 && cyc < 64) begin
            rdy = toggle ? (cyc % 2 == 1) : 1'b1;
            m_tready = rdy;
            a = 10'(exp_seg * 8 + p);
            n_checks++;
            if (m_tvalid !== 1'b1 || m_tdata !== mem_f(a) || m_tlast !== (p == 7) ||
                sts_data[31:24] !== 8'(exp_seg)) begin
                n_fail++;
                $display("FAIL play seg%0d pt%0d: got valid=%b data=%h last=%b seg=%0d, expected valid=1 data=%h last=%b seg=%0d",
                         exp_seg, p, m_tvalid, m_tdata, m_tlast, sts_data[31:24], mem_f(a), (p == 7), exp_seg);
            end
            if (rdy) p++;
            cyc++;
            @(negedge aclk);
        end
        m_tready = 1'b0;
        n_checks++;
        if (p < 8) begin
            n_fail++;
            $display("FAIL play timeout seg%0d: got %0d beats, expected 8", exp_seg, p);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge aclk);
        n_checks++;
        if (m_tvalid !== 1'b0 || overload !== 1'b0 || sts_data !== 32'd0 || bram_rst !== 1'b1 || s_tready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset state: got valid=%b ovl=%b sts=%h brst=%b rdy=%b, expected 0 0 00000000 1 1",
                     m_tvalid, overload, sts_data, bram_rst, s_tready);
        end
        aresetn = 1'b1;
        @(negedge aclk);
        n_checks++;
        if (m_tvalid !== 1'b1 || bram_rst !== 1'b0 || bram_addr !== 10'd0 || m_tlast !== 1'b0 || m_tdata !== mem_f(10'd0)) begin
            n_fail++;
            $display("FAIL after release: got valid=%b brst=%b addr=%0d last=%b data=%h, expected 1 0 0 0 %h",
                     m_tvalid, bram_rst, bram_addr, m_tlast, m_tdata, mem_f(10'd0));
        end
    endtask

    task automatic test_measure();
        set_std_cfg(32'd801);
        apply_reset();
        run_period(16'd0, 16'd100);
        n_checks++;
        if (overload !== 1'b1 || sts_data[23:0] !== 24'd1) begin
            n_fail++;
            $display("FAIL measure thr801: got ovl=%b period=%0d, expected 1 1", overload, sts_data[23:0]);
        end
        thr_v = 32'd800;
        run_period(16'd0, 16'd100);
        n_checks++;
        if (overload !== 1'b0 || sts_data[23:0] !== 24'd2) begin
            n_fail++;
            $display("FAIL measure thr800: got ovl=%b period=%0d, expected 0 2", overload, sts_data[23:0]);
        end
    endtask

    task automatic test_zero_length();
        os_v = 16'd0; ow_v = 16'd4; rp_v = 16'd0; wd_v = 16'd8;
        seglen_v = 32'd8; thr_v = 32'd761;
        apply_reset();
        run_period(16'd5, 16'd100);
        n_checks++;
        if (overload !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_len thr761: got ovl=%b, expected 1", overload);
        end
        thr_v = 32'd760;
        run_period(16'd5, 16'd100);
        n_checks++;
        if (overload !== 1'b0 || sts_data[23:0] !== 24'd2) begin
            n_fail++;
            $display("FAIL zero_len thr760: got ovl=%b period=%0d, expected 0 2", overload, sts_data[23:0]);
        end
    endtask

    task automatic test_segments();
        int seq [8] = '{0, 1, 2, 3, 0, 1, 2, 0};
        set_std_cfg(32'd1000);
        apply_reset();
        for (int k = 0; k < 7; k++) begin
            run_period(16'd0, (k == 6) ? 16'd150 : 16'd100);
            n_checks++;
            if (overload !== ((k == 6) ? 1'b0 : 1'b1)) begin
                n_fail++;
                $display("FAIL segments ovl period%0d: got %b, expected %b", k, overload, (k != 6));
            end
            play_segment(seq[k], k != 0);
        end
        play_segment(seq[7], 1'b1);
    endtask

    task automatic test_negative();
        os_v = 16'd1; ow_v = 16'd4; rp_v = 16'd1; wd_v = 16'd65535;
        seglen_v = 32'd8; thr_v = 32'h8000_0000;
        apply_reset();
        run_period(16'd32767, 16'h8000);
        n_checks++;
        if (overload !== 1'b1 || sts_data[23:0] !== 24'd1) begin
            n_fail++;
            $display("FAIL negative 40bit: got ovl=%b period=%0d, expected 1 1", overload, sts_data[23:0]);
        end
    endtask

    task automatic test_reset_mid();
        set_std_cfg(32'd801);
        apply_reset();
        run_period(16'd0, 16'd100);
        for (int i = 0; i < 11; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = (i >= 7) ? 16'd1000 : 16'd0;
            @(negedge aclk);
        end
        aresetn  = 1'b0;
        s_tvalid = 1'b0;
        #1;
        n_checks++;
        if (m_tvalid !== 1'b0 || overload !== 1'b0 || sts_data !== 32'd0) begin
            n_fail++;
            $display("FAIL reset mid-pulse: got valid=%b ovl=%b sts=%h, expected 0 0 00000000", m_tvalid, overload, sts_data);
        end
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        run_period(16'd0, 16'd100);
        n_checks++;
        if (overload !== 1'b1 || sts_data[23:0] !== 24'd1) begin
            n_fail++;
            $display("FAIL post-reset period: got ovl=%b period=%0d, expected 1 1", overload, sts_data[23:0]);
        end
    endtask

    initial begin
        aresetn  = 1'b0;
        s_tvalid = 1'b0;
        s_tdata  = 16'd0;
        m_tready = 1'b0;
        set_std_cfg(32'd1000);
        test_reset();
        test_measure();
        test_zero_length();
        test_segments();
        test_reset_mid();
        test_negative();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
